gate_bist_checker: RTL and testbench
====================================

Name: gate_bist_checker

Overview:
- Synthesizable stimulus-and-response block for any 2-input logic gate in the library.
- Drives the gate's inputs through all four input combinations and samples the gate output after a settle window.
- Compares each sample against a parameterized truth table and reports per-vector failures and an overall pass flag.
- Sits beside the gate under test and does in hardware what the gate benches do in simulation.

Parameters:
- TRUTH_TABLE, 4'b1110, expected output per vector; bit index = {a,b} (default = OR).
- SETTLE_CYCLES, 4, clock cycles each vector is held before sampling; legal range 1..255.
- CNT_W, 8, width of the settle counter; must hold SETTLE_CYCLES.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  single-cycle request to run one full sweep.
- dut_y  input  1  output of the gate under test.
- dut_a  output  1  gate input a, registered.
- dut_b  output  1  gate input b, registered.
- busy  output  1  high while a sweep is in progress.
- done  output  1  one-cycle pulse when a sweep completes.
- pass  output  1  1 if the last sweep had no mismatches; held until the next start.
- fail_vec  output  4  bit k set if vector k ({a,b}=k) mismatched; held.
- err_count  output  3  number of mismatching vectors in the last sweep (0..4); held.

Behaviour:
- Reset: all outputs are 0 (dut_a, dut_b, busy, done, pass, fail_vec, err_count). The FSM goes to IDLE and the vector index and settle counter clear.
- Reset mid-sweep: the sweep is aborted immediately. No done pulse. pass stays 0.
- FSM states: IDLE, SETTLE, SAMPLE, DONE.
- IDLE:
  - start=1 moves to SETTLE.
  - On that edge: idx=0, {dut_a,dut_b}=2'b00, counter=SETTLE_CYCLES-1, fail_vec/err_count/pass cleared, busy=1.
- SETTLE:
  - Counter decrements each cycle.
  - At counter==0, moves to SAMPLE.
  - dut_a/dut_b stay stable.
- SAMPLE:
  - dut_y is compared with TRUTH_TABLE[idx] on the SAMPLE edge.
  - On mismatch: fail_vec[idx] is set and err_count increments.
  - Any non-matching value, including X/Z in simulation, counts as a mismatch.
  - If idx<3: idx++, {dut_a,dut_b} = idx+1 on the same edge, counter reloaded, back to SETTLE.
  - If idx==3: moves to DONE.
- DONE:
  - done=1 for exactly one cycle.
  - pass = (fail_vec==0), using the final fail_vec including the last sample.
  - busy drops to 0 when entering IDLE on the next edge.
  - {dut_a,dut_b} return to 00 in IDLE.
- Timing: each vector occupies SETTLE_CYCLES+1 cycles. With start sampled high at edge 0, done is high in the cycle after edge 4*(SETTLE_CYCLES+1)+1. Default: 21 cycles.
- start while busy or in DONE is ignored; there is no queueing.
- start held high continuously: a new sweep starts on the first IDLE cycle after DONE.
- Vector order is fixed: 00, 01, 10, 11.
- err_count never exceeds 4 and does not wrap.

Decomposition:
- Shared package gate_bist_pkg:
  - state enum (IDLE/SETTLE/SAMPLE/DONE);
  - NUM_VECTORS=4;
  - truth-table constants TT_AND=4'b1000, TT_OR=4'b1110, TT_XOR=4'b0110, TT_NAND=4'b0111, TT_NOR=4'b0001.
- One natural sub-module: gate_bist_settle_cnt. It is a loadable down-counter with a zero flag, driven by load/en from the FSM.
- Compare logic and FSM stay in the top block.

Test Plan:
- Correct OR model on dut_y, default params, start pulse → vectors 00,01,10,11 each held 5 cycles; done after 21 cycles; pass=1, fail_vec=0000, err_count=0.
- dut_y stuck-at-0, TRUTH_TABLE=TT_OR → fail_vec=1110, err_count=3, pass=0.
- XOR model wired but TRUTH_TABLE=TT_OR → mismatch only on vector 11; fail_vec=1000, err_count=1, pass=0.
- Reset asserted during SETTLE of vector 2 → all outputs 0 asynchronously, no done. A fresh start then completes with pass=1.
- start re-pulsed while busy, and again in the DONE cycle → ignored; exactly one done pulse; results unchanged.
- SETTLE_CYCLES=1, correct AND model with TRUTH_TABLE=TT_AND → each vector held 2 cycles; done after 9 cycles; pass=1.

Source files
------------

// File: rtl/gate_bist_pkg.sv
// Shared types and constants for the 2-input gate self-test block.
package gate_bist_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_e;

  localparam int NUM_VECTORS = 4;

  // Expected gate output per input vector; bit index = {a,b}.
  localparam logic [3:0] TT_AND  = 4'b1000;
  localparam logic [3:0] TT_OR   = 4'b1110;
  localparam logic [3:0] TT_XOR  = 4'b0110;
  localparam logic [3:0] TT_NAND = 4'b0111;
  localparam logic [3:0] TT_NOR  = 4'b0001;

  // Error counter increment that holds at NUM_VECTORS instead of wrapping.
  function automatic logic [2:0] err_sat_inc(input logic [2:0] v);
    logic [2:0] r;
    if (v >= 3'(NUM_VECTORS)) begin
      r = v;
    end else begin
      r = v + 3'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/gate_bist_settle_cnt.sv
// Loadable down-counter with a zero flag; times how long each vector settles.
module gate_bist_settle_cnt #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic             en_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q;

  // Load takes priority; decrement stops at zero so the flag stays asserted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= {CNT_W{1'b0}};
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (en_i && (cnt_q != {CNT_W{1'b0}})) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end else begin
      cnt_q <= cnt_q;
    end
  end

  assign zero_o = (cnt_q == {CNT_W{1'b0}});

endmodule

// File: rtl/gate_bist_checker.sv
// Hardware sweep of a 2-input gate through all four input vectors, comparing
// each settled output against a truth table and reporting per-vector results.
module gate_bist_checker
  import gate_bist_pkg::*;
#(
  parameter logic [3:0] TRUTH_TABLE   = 4'b1110,
  parameter int         SETTLE_CYCLES = 4,
  parameter int         CNT_W         = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       dut_y,
  output logic       dut_a,
  output logic       dut_b,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] fail_vec,
  output logic [2:0] err_count
);

  localparam logic [1:0]       IDX_LAST   = 2'(NUM_VECTORS - 1);
  localparam logic [CNT_W-1:0] SETTLE_RLD = CNT_W'(SETTLE_CYCLES - 1);

  state_e     state_q;
  logic [1:0] idx_q;
  logic       dut_a_q;
  logic       dut_b_q;
  logic       busy_q;
  logic       done_q;
  logic       pass_q;
  logic [3:0] fail_vec_q;
  logic [2:0] err_count_q;

  logic       cnt_load_s;
  logic       cnt_en_s;
  logic       cnt_zero_s;
  logic       exp_bit_s;
  logic       mismatch_s;

  // Case-equality so an X or Z from the gate is treated as a mismatch.
  assign exp_bit_s  = TRUTH_TABLE[idx_q];
  assign mismatch_s = (dut_y !== exp_bit_s);

  // Reload on sweep start and when advancing to the next vector.
  assign cnt_load_s = ((state_q == IDLE) && start) ||
                      ((state_q == SAMPLE) && (idx_q != IDX_LAST));
  assign cnt_en_s   = (state_q == SETTLE);

  gate_bist_settle_cnt #(
    .CNT_W(CNT_W)
  ) u_settle_cnt (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (cnt_load_s),
    .en_i      (cnt_en_s),
    .load_val_i(SETTLE_RLD),
    .zero_o    (cnt_zero_s)
  );

  // Sweep sequencer: drives the vectors, accumulates mismatches, publishes results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= 2'd0;
      dut_a_q     <= 1'b0;
      dut_b_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      fail_vec_q  <= 4'b0000;
      err_count_q <= 3'd0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          dut_a_q <= 1'b0;
          dut_b_q <= 1'b0;
          idx_q   <= 2'd0;
          if (start) begin
            state_q     <= SETTLE;
            fail_vec_q  <= 4'b0000;
            err_count_q <= 3'd0;
            pass_q      <= 1'b0;
            busy_q      <= 1'b1;
          end else begin
            state_q <= IDLE;
          end
        end
        SETTLE: begin
          if (cnt_zero_s) begin
            state_q <= SAMPLE;
          end else begin
            state_q <= SETTLE;
          end
        end
        SAMPLE: begin
          if (mismatch_s) begin
            fail_vec_q[idx_q] <= 1'b1;
            err_count_q       <= err_sat_inc(err_count_q);
          end else begin
            err_count_q <= err_count_q;
          end
          if (idx_q != IDX_LAST) begin
            idx_q              <= idx_q + 2'd1;
            {dut_a_q, dut_b_q} <= idx_q + 2'd1;
            state_q            <= SETTLE;
          end else begin
            state_q <= DONE;
          end
        end
        DONE: begin
          // fail_vec_q already holds the last vector's result from SAMPLE.
          done_q  <= 1'b1;
          pass_q  <= (fail_vec_q == 4'b0000);
          busy_q  <= 1'b0;
          dut_a_q <= 1'b0;
          dut_b_q <= 1'b0;
          idx_q   <= 2'd0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign dut_a     = dut_a_q;
  assign dut_b     = dut_b_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign fail_vec  = fail_vec_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_gate_bist_checker.sv
// Scoreboard bench for gate_bist_checker: two instances (OR/settle 4 and
// AND/settle 1) driven by behavioural gate models.
module tb_gate_bist_checker;
  import gate_bist_pkg::*;

  typedef struct {
    logic [3:0] fv;
    logic [2:0] ec;
    logic       ps;
    int         lat;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start1, start2;
  logic       y1, y2;
  logic       a1, b1, busy1, done1, pass1;
  logic       a2, b2, busy2, done2, pass2;
  logic [3:0] fv1, fv2;
  logic [2:0] ec1, ec2;
  int         mode1;
  bit         sel;

  logic       m_a, m_b, m_busy, m_done, m_pass;
  logic [3:0] m_fv;
  logic [2:0] m_ec;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  // Gate model: 0=OR, 1=stuck-at-0, 2=XOR, 3=AND.
  function automatic logic model_y(input int md, input logic a, input logic b);
    logic r;
    case (md)
      0:       r = a | b;
      1:       r = 1'b0;
      2:       r = a ^ b;
      3:       r = a & b;
      default: r = 1'bx;
    endcase
    return r;
  endfunction

  always_comb y1 = model_y(mode1, a1, b1);
  always_comb y2 = model_y(3, a2, b2);

  always_comb begin
    if (sel) begin
      {m_a, m_b, m_busy, m_done, m_pass, m_fv, m_ec} = {a2, b2, busy2, done2, pass2, fv2, ec2};
    end else begin
      {m_a, m_b, m_busy, m_done, m_pass, m_fv, m_ec} = {a1, b1, busy1, done1, pass1, fv1, ec1};
    end
  end

  gate_bist_checker #(.TRUTH_TABLE(TT_OR), .SETTLE_CYCLES(4), .CNT_W(8)) u_dut_or (
    .clk(clk), .rst_n(rst_n), .start(start1), .dut_y(y1),
    .dut_a(a1), .dut_b(b1), .busy(busy1), .done(done1), .pass(pass1),
    .fail_vec(fv1), .err_count(ec1)
  );

  gate_bist_checker #(.TRUTH_TABLE(TT_AND), .SETTLE_CYCLES(1), .CNT_W(8)) u_dut_and (
    .clk(clk), .rst_n(rst_n), .start(start2), .dut_y(y2),
    .dut_a(a2), .dut_b(b2), .busy(busy2), .done(done2), .pass(pass2),
    .fail_vec(fv2), .err_count(ec2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic set_start(input bit s, input logic v);
    if (s) start2 = v;
    else   start1 = v;
  endtask

  // Counts done pulses of the selected instance over n cycles.
  task automatic count_done(input int n, output int cnt);
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (m_done) cnt++;
    end
  endtask

  // One sweep: push the expected result, start, check vectors while busy,
  // then pop and compare when done fires.
  task automatic run_sweep(input bit s, input int settle, input logic [3:0] tt,
                           input int md, input bit repulse, output exp_t got_item);
    exp_t e_item;
    exp_t p;
    int   cyc;
    bit   seen;
    int   per;
    logic [1:0] kv;
    logic y;
    sel  = s;
    per  = settle + 1;
    if (!s) mode1 = md;
    e_item.fv = 4'b0000;
    e_item.ec = 3'd0;
    for (int k = 0; k < 4; k++) begin
      kv = 2'(k);
      y  = model_y(s ? 3 : md, kv[1], kv[0]);
      if (y !== tt[k]) begin
        e_item.fv[k] = 1'b1;
        e_item.ec    = e_item.ec + 3'd1;
      end
    end
    e_item.ps  = (e_item.fv == 4'b0000);
    e_item.lat = 4 * per + 1;
    exp_q.push_back(e_item);

    @(negedge clk);
    set_start(s, 1'b1);
    @(negedge clk);
    cyc  = 0;
    seen = 0;
    while (!seen && cyc < e_item.lat + 20) begin
      set_start(s, repulse && (cyc == 7 || cyc == 4 * per));
      if (m_done) begin
        seen = 1;
      end else begin
        if (cyc == 0) check("busy_start", m_busy, 1);
        if (cyc < 4 * per && (cyc % per == 0 || cyc % per == settle))
          check("vector", {m_a, m_b}, cyc / per);
        @(negedge clk);
        cyc++;
      end
    end
    set_start(s, 1'b0);
    p = exp_q.pop_front();
    got_item = p;
    if (!seen) begin
      check("done_timeout", 0, 1);
    end else begin
      check("latency", cyc, p.lat);
      check("fail_vec", m_fv, p.fv);
      check("err_count", m_ec, p.ec);
      check("pass", m_pass, p.ps);
      check("busy_at_done", m_busy, 0);
    end
    @(negedge clk);
    check("done_one_cycle", m_done, 0);
    check("ab_idle", {m_a, m_b}, 0);
  endtask

  initial begin
    exp_t r;
    int   nd;
    rst_n = 1'b0; start1 = 1'b0; start2 = 1'b0; mode1 = 0; sel = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_or",  {a1, b1, busy1, done1, pass1, fv1, ec1}, 0);
    check("reset_and", {a2, b2, busy2, done2, pass2, fv2, ec2}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    run_sweep(1'b0, 4, TT_OR, 0, 1'b0, r);   // correct OR gate
    run_sweep(1'b0, 4, TT_OR, 1, 1'b0, r);   // stuck-at-0
    run_sweep(1'b0, 4, TT_OR, 2, 1'b0, r);   // XOR wired, OR expected

    // Reset during SETTLE of vector 2 aborts the sweep without done.
    sel = 1'b0; mode1 = 0;
    @(negedge clk); start1 = 1'b1;
    @(negedge clk); start1 = 1'b0;
    repeat (12) @(negedge clk);
    check("mid_vector2", {a1, b1}, 2);
    #2 rst_n = 1'b0;
    #1 check("reset_async", {a1, b1, busy1, done1, pass1, fv1, ec1}, 0);
    @(negedge clk); rst_n = 1'b1;
    count_done(30, nd);
    check("no_done_after_abort", nd, 0);
    run_sweep(1'b0, 4, TT_OR, 0, 1'b0, r);

    // Extra starts while busy and in DONE are ignored.
    run_sweep(1'b0, 4, TT_OR, 2, 1'b1, r);
    count_done(30, nd);
    check("no_second_done", nd, 0);
    check("busy_stays_low", busy1, 0);
    check("held_fail_vec", fv1, r.fv);
    check("held_err_count", ec1, r.ec);
    check("held_pass", pass1, r.ps);

    run_sweep(1'b1, 1, TT_AND, 3, 1'b0, r);  // AND, settle 1

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
